imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, the fetch address width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 64, the number of 32-bit instruction words (power of 2, at least 4).
REQ-003 The block SHALL have parameter NOP, default 32'h00000033 (add x0,x0,x0), the fill and substitute word.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port ld_valid, input, 1 bit: ld_data carries a program word.
REQ-007 The block SHALL have port ld_data, input, 32 bits: the program word.
REQ-008 The block SHALL have port ld_last, input, 1 bit: the current load word is the final one.
REQ-009 The block SHALL have port ld_ready, output, 1 bit: the block accepts a load word this cycle.
REQ-010 The block SHALL have port reload, input, 1 bit: single-cycle request to re-initialise.
REQ-011 The block SHALL have port busy, output, 1 bit: high in the CLEAR and LOAD states.
REQ-012 The block SHALL have port fetch_req, input, 1 bit: fetch request.
REQ-013 The block SHALL have port fetch_addr, input, ADDR_W bits: byte address.
REQ-014 The block SHALL have port stall, input, 1 bit: hold the fetch output.
REQ-015 The block SHALL have port flush, input, 1 bit: kill the fetch output.
REQ-016 The block SHALL have port inst, output, 32 bits: fetched instruction.
REQ-017 The block SHALL have port inst_valid, output, 1 bit: inst is valid.
REQ-018 The block SHALL have port fault, output, 2 bits: bit0 = misaligned, bit1 = out of range.

Function
REQ-019 The FSM SHALL have three states: CLEAR, LOAD and RUN.
REQ-020 In CLEAR, the block SHALL write NOP to word ptr each cycle (ptr 0 to DEPTH-1), then go to LOAD with ptr = 0; CLEAR therefore lasts exactly DEPTH cycles.
REQ-021 In LOAD, ld_ready SHALL be 1; each cycle with ld_valid=1, ld_data SHALL be written to word ptr and ptr incremented.
REQ-022 In LOAD, an accepted word with ld_last=1, or an accepted word at ptr = DEPTH-1, SHALL move the FSM to RUN on the next cycle.
REQ-023 In LOAD, cycles with ld_valid=0 SHALL leave ptr and memory unchanged.
REQ-024 In CLEAR and RUN, ld_ready SHALL be 0 and ld_valid SHALL be ignored, so no overflow write past DEPTH-1 occurs.
REQ-025 In RUN, reload=1 SHALL send the FSM to CLEAR, clear inst_valid and fault, and set inst=NOP; in CLEAR and LOAD, reload SHALL be ignored.
REQ-026 Fetch SHALL use one-cycle latency: a fetch_req accepted at edge n SHALL update inst, inst_valid and fault at edge n+1.
REQ-027 A fetch_req SHALL be accepted only in RUN with stall=0 and flush=0.
REQ-028 The word index SHALL be fetch_addr[ADDR_W-1:2].
REQ-029 If fetch_addr[1:0] != 0, the block SHALL set fault[0]=1.
REQ-030 If index >= DEPTH, the block SHALL set fault[1]=1; both fault bits may be set together.
REQ-031 On any fault, the block SHALL drive inst=NOP and inst_valid=1.
REQ-032 With no fault, inst SHALL be mem[index], fault=00 and inst_valid=1.
REQ-033 In RUN with stall=0, flush=0 and fetch_req=0, the block SHALL set inst_valid=0 and leave inst and fault unchanged.
REQ-034 With stall=1 and flush=0, inst, inst_valid and fault SHALL hold, and fetch_req SHALL be ignored.
REQ-035 With flush=1, which has priority over stall and fetch_req, the next edge SHALL give inst_valid=0, inst=NOP and fault=00.
REQ-036 Outside RUN, inst_valid SHALL be 0, fault SHALL be 00 and inst SHALL be NOP.
REQ-037 Memory writes and fetch reads never occur in the same cycle, so no read/write collision exists.

Reset
REQ-038 rst=1 at an edge SHALL force state=CLEAR, ptr=0, inst=NOP, inst_valid=0, fault=00, ld_ready=0 and busy=1.
REQ-039 rst SHALL take priority over all other inputs, including when asserted mid-CLEAR, mid-LOAD or mid-fetch.
REQ-040 Any reset SHALL restart the full CLEAR sequence, which refills all DEPTH words with NOP.

Verification
REQ-041 Release rst with DEPTH=64 -> busy=1 and ld_ready=0 for 64 cycles, then ld_ready=1.
REQ-042 Load 0x00002083, 0x00402103, 0x00802183 (ld_last on the third), then fetch 0x4 -> inst=0x00402103 one cycle later with inst_valid=1 and fault=00; fetch 0xC -> inst=0x00000033.
REQ-043 Fetch 0x6 -> NOP, fault=01; fetch 0x100 -> NOP, fault=10; fetch 0x102 -> NOP, fault=11; inst_valid=1 in all three cases.
REQ-044 Fetch 0x0, then stall for 2 cycles while requesting 0x8 -> inst holds 0x00002083; apply stall and flush together -> inst_valid=0, inst=NOP.
REQ-045 Stream 65 words with ld_valid held and no ld_last -> RUN after word 64, word 65 is ignored, and fetch 0xFC returns word 64.
REQ-046 Pulse reload in RUN, or rst mid-LOAD after 2 words -> busy=1 for 64 cycles, and fetch 0x0 after RUN returns NOP if nothing is reloaded.

Source files
------------

// File: rtl/imem_loader_if.sv
// Loader, control and fetch signals of the instruction memory loader, grouped for port use.
// master drives loads/fetches (core/host side); slave is the loader itself.
interface imem_loader_if #(
    parameter int ADDR_W = 32
);
    logic              ld_valid;
    logic [31:0]       ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              reload;
    logic              busy;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              stall;
    logic              flush;
    logic [31:0]       inst;
    logic              inst_valid;
    logic [1:0]        fault;

    modport master (
        output ld_valid, ld_data, ld_last, reload, fetch_req, fetch_addr, stall, flush,
        input  ld_ready, busy, inst, inst_valid, fault
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, reload, fetch_req, fetch_addr, stall, flush,
        output ld_ready, busy, inst, inst_valid, fault
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory: NOP-fills all words, accepts a program stream, then serves fetches one cycle after request.
// Load words are taken only in LOAD (ld_ready); stall holds and flush kills the registered fetch output.
module imem_loader #(
    parameter int          ADDR_W = 32,
    parameter int          DEPTH  = 64,
    parameter logic [31:0] NOP    = 32'h00000033
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [31:0]       inst_q, inst_d;
    logic              vld_q, vld_d;
    logic [1:0]        fault_q, fault_d;
    logic              mem_we;
    logic [31:0]       mem_wdat;
    logic [31:0]       mem_q [DEPTH];

    logic              mis, oor;
    logic [PTR_W-1:0]  rd_idx;

    // Any index bit above the memory range means the word lies past DEPTH-1.
    assign mis    = |bus.fetch_addr[1:0];
    assign oor    = |bus.fetch_addr[ADDR_W-1:PTR_W+2];
    assign rd_idx = bus.fetch_addr[PTR_W+1:2];

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        mem_we   = 1'b0;
        mem_wdat = NOP;
        inst_d   = inst_q;
        vld_d    = vld_q;
        fault_d  = fault_q;

        case (state_q)
            CLEAR: begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + PTR_W'(1);
                if (ptr_q == LAST) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (bus.ld_valid) begin
                    mem_we   = 1'b1;
                    mem_wdat = bus.ld_data;
                    ptr_d    = ptr_q + PTR_W'(1);
                    if (bus.ld_last || ptr_q == LAST) begin
                        state_d = RUN;
                        ptr_d   = '0;
                    end
                end
            end
            RUN: begin
                if (bus.reload) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase

        // Fetch output path; reload and flush both force the idle/NOP output.
        if (state_q != RUN || bus.reload || bus.flush) begin
            inst_d  = NOP;
            vld_d   = 1'b0;
            fault_d = 2'b00;
        end else if (!bus.stall) begin
            if (bus.fetch_req) begin
                vld_d   = 1'b1;
                fault_d = {oor, mis};
                inst_d  = (oor || mis) ? NOP : mem_q[rd_idx];
            end else begin
                vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            inst_q  <= NOP;
            vld_q   <= 1'b0;
            fault_q <= 2'b00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            inst_q  <= inst_d;
            vld_q   <= vld_d;
            fault_q <= fault_d;
        end
    end

    // Storage carries no reset; every reset path runs CLEAR, which refills it.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[ptr_q] <= mem_wdat;
        end
    end

    assign bus.ld_ready   = (state_q == LOAD);
    assign bus.busy       = (state_q != RUN);
    assign bus.inst       = inst_q;
    assign bus.inst_valid = vld_q;
    assign bus.fault      = fault_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: clear timing, loading, fetch faults, stall/flush, reload and reset.
module tb_imem_loader;
    localparam logic [31:0] NOP = 32'h00000033;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    imem_loader_if #(.ADDR_W(32)) bus ();

    imem_loader #(.ADDR_W(32), .DEPTH(64), .NOP(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] i, input logic v, input logic [1:0] f);
        chk({tag, ".inst"}, bus.inst, i);
        chk({tag, ".vld"}, {31'd0, bus.inst_valid}, {31'd0, v});
        chk({tag, ".fault"}, {30'd0, bus.fault}, {30'd0, f});
    endtask

    // Counts the 64 CLEAR edges following a reset/reload edge; optional reload pulse mid-clear.
    task automatic clear_seq(input string tag, input bit poke_reload);
        for (int i = 1; i <= 64; i++) begin
            step();
            if (poke_reload) bus.reload = (i == 10);
            if (i == 1 || i == 63) begin
                chk({tag, ".busy"}, {31'd0, bus.busy}, 32'd1);
                chk({tag, ".rdy_lo"}, {31'd0, bus.ld_ready}, 32'd0);
                chk_out({tag, ".idle"}, NOP, 1'b0, 2'b00);
            end
        end
        chk({tag, ".rdy_hi"}, {31'd0, bus.ld_ready}, 32'd1);
        chk({tag, ".busy_ld"}, {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic load(input logic [31:0] d, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        bus.ld_last  = last;
        step();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0; bus.reload = 1'b0;
        bus.fetch_req = 1'b0; bus.fetch_addr = '0; bus.stall = 1'b0; bus.flush = 1'b0;

        step(); step();
        chk("rst.busy", {31'd0, bus.busy}, 32'd1);
        chk("rst.rdy", {31'd0, bus.ld_ready}, 32'd0);
        chk_out("rst", NOP, 1'b0, 2'b00);

        rst = 1'b0;
        clear_seq("clr0", 1'b0);

        load(32'h00002083, 1'b0);
        chk("ld.rdy_mid", {31'd0, bus.ld_ready}, 32'd1);
        load(32'h00402103, 1'b0);
        load(32'h00802183, 1'b1);
        chk("ld.rdy_run", {31'd0, bus.ld_ready}, 32'd0);
        chk("ld.busy_run", {31'd0, bus.busy}, 32'd0);

        fetch(32'h4);   chk_out("f4", 32'h00402103, 1'b1, 2'b00);
        fetch(32'hC);   chk_out("fC", NOP, 1'b1, 2'b00);
        fetch(32'h6);   chk_out("f6", NOP, 1'b1, 2'b01);
        fetch(32'h100); chk_out("f100", NOP, 1'b1, 2'b10);
        fetch(32'h102); chk_out("f102", NOP, 1'b1, 2'b11);
        fetch(32'h8);   chk_out("f8", 32'h00802183, 1'b1, 2'b00);
        bus.fetch_req = 1'b0;
        step();         chk_out("noreq", 32'h00802183, 1'b0, 2'b00);

        fetch(32'h0);   chk_out("f0", 32'h00002083, 1'b1, 2'b00);
        bus.stall = 1'b1;
        fetch(32'h8);   chk_out("stall1", 32'h00002083, 1'b1, 2'b00);
        step();         chk_out("stall2", 32'h00002083, 1'b1, 2'b00);
        bus.flush = 1'b1;
        step();         chk_out("stflush", NOP, 1'b0, 2'b00);
        bus.stall = 1'b0; bus.flush = 1'b0;
        fetch(32'h6);   chk_out("f6b", NOP, 1'b1, 2'b01);
        bus.stall = 1'b1;
        fetch(32'h4);   chk_out("stfault", NOP, 1'b1, 2'b01);
        bus.stall = 1'b0;

        // Reload, with a second reload pulse inside CLEAR that must be ignored.
        fetch(32'h4);   chk_out("f4b", 32'h00402103, 1'b1, 2'b00);
        bus.reload = 1'b1;
        step();
        bus.reload = 1'b0;
        bus.fetch_req = 1'b0;
        chk_out("reload", NOP, 1'b0, 2'b00);
        clear_seq("clr1", 1'b1);
        load(32'hDEADBEEF, 1'b1);
        fetch(32'h0);   chk_out("rl.f0", 32'hDEADBEEF, 1'b1, 2'b00);
        fetch(32'h4);   chk_out("rl.f4", NOP, 1'b1, 2'b00);
        bus.fetch_req = 1'b0;
        bus.reload = 1'b1;
        step();
        bus.reload = 1'b0;
        clear_seq("clr2", 1'b0);

        // Reset in the middle of LOAD restarts the full clear.
        load(32'hAAAA0001, 1'b0);
        load(32'hAAAA0002, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstld.busy", {31'd0, bus.busy}, 32'd1);
        clear_seq("clr3", 1'b0);

        // 65-word stream without ld_last: word 65 must not land anywhere.
        bus.ld_valid = 1'b1;
        for (int i = 1; i <= 65; i++) begin
            bus.ld_data = 32'h10000000 + 32'(i);
            step();
            if (i == 63) chk("str.rdy63", {31'd0, bus.ld_ready}, 32'd1);
            if (i == 64) chk("str.run", {31'd0, bus.busy}, 32'd0);
        end
        bus.ld_valid = 1'b0;
        chk("str.rdy65", {31'd0, bus.ld_ready}, 32'd0);
        fetch(32'hFC);  chk_out("str.fFC", 32'h10000040, 1'b1, 2'b00);
        fetch(32'h0);   chk_out("str.f0", 32'h10000001, 1'b1, 2'b00);

        // Reset together with a fetch request.
        rst = 1'b1;
        fetch(32'h4);
        chk_out("rstf", NOP, 1'b0, 2'b00);
        chk("rstf.busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b0;
        bus.fetch_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
